if_inst_queue: RTL and testbench

Fetch-to-decode instruction queue sitting directly downstream of the fetch-translate stage and upstream of decode. It accepts the one or two instructions that fetch hands over each cycle from a 64-bit aligned fetch word. It stores them as single-instruction entries in a circular buffer and presents the oldest one or two to decode in first-word-fall-through order. It decouples fetch stalls from decode stalls and discards all contents on an exception or branch flush.

---
 rtl/if_inst_queue_pkg.sv | 30 +++
 rtl/if_inst_queue_regfile.sv | 37 +++
 rtl/if_inst_queue.sv | 140 ++++++++++++++
 tb/tb_if_inst_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_inst_queue_pkg.sv
// Shared bus layout for the fetch-to-decode instruction queue.
// Entry = {pc, inst, excep}; fetch bus = {pc, inst_pair, excep}.
package if_inst_queue_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int PAIR_W = 64;

    function automatic int iq_entry_width(input int exw);
        return PC_W + INST_W + exw;
    endfunction

    function automatic int if_to_iq_bus_width(input int exw);
        return PC_W + PAIR_W + exw;
    endfunction

    function automatic int iq_to_id_bus_width(input int exw);
        return 2 * iq_entry_width(exw);
    endfunction

    // Field offsets within the fetch bus; excep sits at bit 0
    function automatic int ibus_inst_off(input int exw);
        return exw;
    endfunction

    function automatic int ibus_pc_off(input int exw);
        return exw + PAIR_W;
    endfunction

endpackage

// File: rtl/if_inst_queue_regfile.sv
// Entry storage: DEPTH entries, two write ports, two combinational read ports.
// Contents are deliberately not reset; validity is tracked by the queue count.
module iq_regfile
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 72
) (
    input  logic                     clk,
    input  logic                     we0_i,
    input  logic [$clog2(DEPTH)-1:0] waddr0_i,
    input  logic [W-1:0]             wdata0_i,
    input  logic                     we1_i,
    input  logic [$clog2(DEPTH)-1:0] waddr1_i,
    input  logic [W-1:0]             wdata1_i,
    input  logic [$clog2(DEPTH)-1:0] raddr0_i,
    output logic [W-1:0]             rdata0_o,
    input  logic [$clog2(DEPTH)-1:0] raddr1_i,
    output logic [W-1:0]             rdata1_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write ports; the two addresses of one push are always distinct
    always_ff @(posedge clk) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/if_inst_queue.sv
// Fetch-to-decode instruction queue: splits 64-bit fetch words into single
// instruction entries and presents the oldest two to decode (FWFT).
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int EXW   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  line1_pre_to_now_valid_i,
    input  logic                                  line2_pre_to_now_valid_i,
    input  logic [if_to_iq_bus_width(EXW)-1:0]    pre_to_ibus,
    output logic                                  now_allowin_o,
    input  logic                                  excep_flush_i,
    input  logic                                  branch_flush_i,
    input  logic [1:0]                            next_pop_num_i,
    output logic                                  line1_now_to_next_valid_o,
    output logic                                  line2_now_to_next_valid_o,
    output logic [iq_to_id_bus_width(EXW)-1:0]    to_next_obus,
    output logic                                  error_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = iq_entry_width(EXW);
    localparam logic [CW-1:0] FREE_LIM  = CW'(DEPTH - 2);
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              flush_s;
    logic [1:0]        push_num_s;
    logic [1:0]        pop_eff_s;
    logic              over_pop_s;
    logic [PC_W-1:0]   pc_s;
    logic [PAIR_W-1:0] pair_s;
    logic [EXW-1:0]    excep_s;
    logic              we0_s, we1_s;
    logic [EW-1:0]     wdata0_s, wdata1_s;
    logic [EW-1:0]     rdata0_s, rdata1_s;

    assign flush_s = excep_flush_i | branch_flush_i;
    assign pc_s    = pre_to_ibus[ibus_pc_off(EXW) +: PC_W];
    assign pair_s  = pre_to_ibus[ibus_inst_off(EXW) +: PAIR_W];
    assign excep_s = pre_to_ibus[EXW-1:0];

    // Registered count only: keeps next_pop_num_i off the allowin path
    assign now_allowin_o = ~flush_s & (count_q <= FREE_LIM);

    // Split the fetch word into one or two entries
    always_comb begin
        push_num_s = 2'd0;
        we0_s      = 1'b0;
        we1_s      = 1'b0;
        wdata0_s   = {pc_s, pair_s[31:0], excep_s};
        wdata1_s   = {pc_s + 32'd4, pair_s[63:32], excep_s};
        if (line1_pre_to_now_valid_i & now_allowin_o) begin
            if (pc_s[2]) begin
                push_num_s = 2'd1;
                we0_s      = 1'b1;
                wdata0_s   = {pc_s, pair_s[63:32], excep_s};
            end else if (line2_pre_to_now_valid_i) begin
                push_num_s = 2'd2;
                we0_s      = 1'b1;
                we1_s      = 1'b1;
            end else begin
                push_num_s = 2'd1;
                we0_s      = 1'b1;
            end
        end else begin
            push_num_s = 2'd0;
        end
    end

    assign over_pop_s = ({{(CW-2){1'b0}}, next_pop_num_i} > count_q);
    assign error_o    = over_pop_s | (next_pop_num_i == 2'd3);

    // Clamp the pop to occupancy; over-pop only happens with count <= 2
    always_comb begin
        pop_eff_s = next_pop_num_i;
        if (over_pop_s) begin
            pop_eff_s = count_q[1:0];
        end else begin
            pop_eff_s = next_pop_num_i;
        end
    end

    // Pointer and occupancy update; flush empties the queue
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_num_s);
            rd_ptr_d = rd_ptr_q + AW'(pop_eff_s);
            count_d  = count_q + CW'(push_num_s) - CW'(pop_eff_s);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    iq_regfile #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_regfile (
        .clk      (clk),
        .we0_i    (we0_s),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (wdata0_s),
        .we1_i    (we1_s),
        .waddr1_i (wr_ptr_q + PTR_ONE),
        .wdata1_i (wdata1_s),
        .raddr0_i (rd_ptr_q),
        .rdata0_o (rdata0_s),
        .raddr1_i (rd_ptr_q + PTR_ONE),
        .rdata1_o (rdata1_s)
    );

    assign line1_now_to_next_valid_o = (count_q >= CW'(1));
    assign line2_now_to_next_valid_o = (count_q >= CW'(2));
    assign to_next_obus              = {rdata1_s, rdata0_s};

endmodule

// File: tb/tb_if_inst_queue.sv
// Self-checking bench for if_inst_queue: directed steps then random traffic,
// compared against a queue-of-entries reference model.
module tb_if_inst_queue;

    localparam int DEPTH = 8;
    localparam int EXW   = 8;
    localparam int EW    = 64 + EXW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              line1_i, line2_i;
    logic [96+EXW-1:0] pre_to_ibus;
    logic              now_allowin_o;
    logic              excep_flush_i, branch_flush_i;
    logic [1:0]        next_pop_num_i;
    logic              line1_o, line2_o;
    logic [2*EW-1:0]   to_next_obus;
    logic              error_o;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] mq [$];
    logic [31:0]   fpc;
    int            last_push;

    always #5 clk = ~clk;

    if_inst_queue #(.DEPTH(DEPTH), .EXW(EXW)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .line1_pre_to_now_valid_i  (line1_i),
        .line2_pre_to_now_valid_i  (line2_i),
        .pre_to_ibus               (pre_to_ibus),
        .now_allowin_o             (now_allowin_o),
        .excep_flush_i             (excep_flush_i),
        .branch_flush_i            (branch_flush_i),
        .next_pop_num_i            (next_pop_num_i),
        .line1_now_to_next_valid_o (line1_o),
        .line2_now_to_next_valid_o (line2_o),
        .to_next_obus              (to_next_obus),
        .error_o                   (error_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input logic [1:0] pop);
        line1_i        = 1'b0;
        line2_i        = 1'b0;
        pre_to_ibus    = '0;
        excep_flush_i  = 1'b0;
        branch_flush_i = 1'b0;
        next_pop_num_i = pop;
        #1;
    endtask

    // One clock: drive, check combinational outputs against the model, advance the model
    task automatic step(input logic l1, input logic l2, input logic [31:0] pc,
                        input logic [63:0] pair, input logic [EXW-1:0] ex,
                        input logic ef, input logic bf, input logic [1:0] pop);
        logic          exp_allow;
        int            n, pe, pn;
        logic [EW-1:0] ea, eb;
        line1_i        = l1;
        line2_i        = l2;
        pre_to_ibus    = {pc, pair, ex};
        excep_flush_i  = ef;
        branch_flush_i = bf;
        next_pop_num_i = pop;
        #1;
        n         = mq.size();
        exp_allow = !(ef || bf) && (DEPTH - n >= 2);
        chk("allowin", now_allowin_o, exp_allow);
        chk("line1_valid", line1_o, n >= 1);
        chk("line2_valid", line2_o, n >= 2);
        chk("error", error_o, (int'(pop) > n) || (pop == 2'd3));
        if (n >= 1) chk("entry0", to_next_obus[EW-1:0], mq[0]);
        if (n >= 2) chk("entry1", to_next_obus[2*EW-1:EW], mq[1]);
        pn = 0;
        ea = '0;
        eb = '0;
        if (l1 && exp_allow) begin
            if (pc[2]) begin
                ea = {pc, pair[63:32], ex};
                pn = 1;
            end else begin
                ea = {pc, pair[31:0], ex};
                eb = {pc + 32'd4, pair[63:32], ex};
                pn = l2 ? 2 : 1;
            end
        end
        @(posedge clk);
        if (ef || bf) begin
            mq.delete();
        end else begin
            pe = (int'(pop) < n) ? int'(pop) : n;
            repeat (pe) void'(mq.pop_front());
            if (pn >= 1) mq.push_back(ea);
            if (pn == 2) mq.push_back(eb);
        end
        last_push = pn;
        @(negedge clk);
    endtask

    // Fetch model: sequential PCs, holds its word until accepted
    task automatic fetch_step(input logic l1, input logic ef, input logic bf,
                              input logic [1:0] pop, input logic l2);
        logic [63:0] pair;
        pair = {$urandom, $urandom};
        step(l1, l2, fpc, pair, 8'($urandom), ef, bf, pop);
        fpc = fpc + 32'(4 * last_push);
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          pe;
        rst_n = 1'b0;
        idle(2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 1'b0, 2'd0);

        // Aligned two-instruction push
        step(1'b1, 1'b1, 32'h1C000000, 64'h22223333_44445555, 8'h5A, 1'b0, 1'b0, 2'd0);
        idle(2'd0);
        chk("tp_entry0", to_next_obus[EW-1:EXW], {32'h1C000000, 32'h44445555});
        chk("tp_entry1", to_next_obus[2*EW-1:EW+EXW], {32'h1C000004, 32'h22223333});
        chk("tp_v2", line2_o, 1'b1);

        // Odd-word PC pushes exactly one entry
        step(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 32'h1C000004, 64'hAAAABBBB_CCCCDDDD, 8'h11, 1'b0, 1'b0, 2'd0);
        idle(2'd0);
        chk("odd_v1", line1_o, 1'b1);
        chk("odd_v2", line2_o, 1'b0);
        chk("odd_entry0", to_next_obus[EW-1:EXW], {32'h1C000004, 32'hAAAABBBB});

        // Fill to 7, check allowin drops, then pop 2
        fpc = 32'h1C000008;
        repeat (3) fetch_step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        idle(2'd0);
        chk("full_allowin", now_allowin_o, 1'b0);
        fetch_step(1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
        idle(2'd0);
        chk("after_pop_allowin", now_allowin_o, 1'b1);

        // Flush at count 6 while pushing 2 and popping 1
        while (mq.size() < 6) fetch_step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        fetch_step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
        idle(2'd0);
        chk("flush_v1", line1_o, 1'b0);
        chk("flush_v2", line2_o, 1'b0);
        chk("flush_allowin", now_allowin_o, 1'b1);

        // Advance pointers to DEPTH-1, then streaming push 2 / pop 2 across the wrap
        fpc = 32'h1C000104;
        repeat (7) begin
            fpc[2] = 1'b1;
            fetch_step(1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        end
        step(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 1'b0, 2'd1);
        fpc    = 32'h1C000200;
        exp_pc = fpc;
        repeat (20) begin
            idle(2'd2);
            if (line1_o) chk("wrap_pc", to_next_obus[EW-1:EW-32], exp_pc);
            pe = (mq.size() < 2) ? mq.size() : 2;
            fetch_step(1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
            exp_pc = exp_pc + 32'(4 * pe);
        end

        // Over-pop with count 1
        step(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b0, 32'h1C000300, 64'h1, 8'h0, 1'b0, 1'b0, 2'd0);
        idle(2'd2);
        chk("overpop_error", error_o, 1'b1);
        step(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 1'b0, 2'd2);
        idle(2'd0);
        chk("overpop_empty", line1_o, 1'b0);
        chk("overpop_allowin", now_allowin_o, 1'b1);

        // Illegal pop encoding on an empty queue
        idle(2'd3);
        chk("pop3_error", error_o, 1'b1);
        step(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 1'b0, 2'd3);

        // Reset together with flush and a push, with content present
        fpc = 32'h1C000400;
        repeat (2) fetch_step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        rst_n          = 1'b0;
        line1_i        = 1'b1;
        line2_i        = 1'b1;
        excep_flush_i  = 1'b1;
        @(posedge clk);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2'd0);
        chk("rst_v1", line1_o, 1'b0);
        chk("rst_allowin", now_allowin_o, 1'b1);

        // Random traffic
        fpc = 32'h1C001000;
        repeat (600) begin
            fetch_step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                       $urandom_range(0, 49) == 0, 2'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
